// File: rtl/mem_fill_responder.sv
// mem_fill_responder: memory-side end of the cache fill interface.
// Single-port, word-addressed data memory. Accepts one read or write per
// cycle with no backpressure; read data returns exactly LATENCY cycles after
// issue through a {valid,data} shift register, strictly in issue order.
module mem_fill_responder #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Word storage; contents survive reset.
    logic [DATA_W-1:0] mem [DEPTH];

    // Word index: byte bit 0 dropped, bits above DEPTH_LOG2 alias.
    logic [DEPTH_LOG2-1:0] index;
    assign index = addr[DEPTH_LOG2:1];

    // Address bits that intentionally take no part in decoding.
    logic unused_addr;
    assign unused_addr = ^{addr[ADDR_W-1:DEPTH_LOG2+1], addr[0]};

    // Read pipeline: entry 0 is stage 1, entry LATENCY-1 drives the outputs.
    logic [LATENCY-1:0] vld_p;
    logic [DATA_W-1:0]  data_p [LATENCY];

    // Write port: a write in a reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (enable && wr && !rst) begin
            mem[index] <= data_in;
        end
    end

    // Data path of the read pipeline; no reset, qualified by vld_p.
    always_ff @(posedge clk) begin
        // stage 1: sample the array at issue (old data if written next cycle)
        data_p[0] <= mem[index];
        // stages 2..LATENCY: plain shift
        for (int i = 1; i < LATENCY; i++) begin
            data_p[i] <= data_p[i-1];
        end
    end

    // Valid bits of the read pipeline; reset discards in-flight reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= enable & ~wr;
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // Outputs come straight from the last stage; data forced to 0 when idle.
    assign data_valid = vld_p[LATENCY-1];
    assign data_out   = vld_p[LATENCY-1] ? data_p[LATENCY-1] : '0;
    assign busy       = |vld_p;

endmodule

// File: tb/tb_mem_fill_responder.sv
// Testbench for mem_fill_responder: directed scenarios followed by random
// traffic, every cycle compared against a per-cycle expectation schedule.
module tb_mem_fill_responder;

    localparam int LAT   = 4;
    localparam int DEPTH = 1024;
    localparam int MAXC  = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out;
    logic        data_valid;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: array contents plus the outputs expected in each cycle.
    logic [15:0] mm [DEPTH];
    bit          known [DEPTH];
    bit          exp_vld [MAXC];
    logic [15:0] exp_data [MAXC];
    bit          exp_known [MAXC];

    mem_fill_responder #(
        .ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(10), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(data_out), .data_valid(data_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Illegal request: enable with an unknown direction.
    always @(posedge clk) begin
        if (enable === 1'b1 && $isunknown(wr)) begin
            $error("FAIL illegal_wr_x cyc=%0d", cyc);
        end
    end

    // One clock cycle: drive request, check outputs mid-cycle, update model.
    task automatic step(input bit r, input bit e, input bit w,
                        input logic [15:0] a, input logic [15:0] d);
        int idx;
        bit eb;
        rst = r; enable = e; wr = w; addr = a; data_in = d;
        @(negedge clk);
        if (cyc > 0) begin
            eb = 1'b0;
            for (int k = cyc; k < cyc + LAT; k++) eb |= exp_vld[k];
            checks++;
            assert (data_valid === exp_vld[cyc]) else begin
                failures++;
                $error("FAIL data_valid cyc=%0d got=%b exp=%b", cyc, data_valid, exp_vld[cyc]);
            end
            if (!exp_vld[cyc] || exp_known[cyc]) begin
                checks++;
                assert (data_out === (exp_vld[cyc] ? exp_data[cyc] : 16'h0)) else begin
                    failures++;
                    $error("FAIL data_out cyc=%0d got=%h exp=%h", cyc, data_out,
                           exp_vld[cyc] ? exp_data[cyc] : 16'h0);
                end
            end
            checks++;
            assert (busy === eb) else begin
                failures++;
                $error("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, eb);
            end
        end
        idx = (int'(a) >> 1) % DEPTH;
        if (r) begin
            for (int k = cyc + 1; k <= cyc + LAT; k++) exp_vld[k] = 1'b0;
        end else if (e && w) begin
            mm[idx] = d;
            known[idx] = 1'b1;
        end else if (e) begin
            exp_vld[cyc + LAT]   = 1'b1;
            exp_data[cyc + LAT]  = mm[idx];
            exp_known[cyc + LAT] = known[idx];
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        for (int i = 0; i < MAXC; i++) begin
            exp_vld[i] = 1'b0; exp_data[i] = '0; exp_known[i] = 1'b0;
        end
        @(posedge clk);
        #1;

        // Reset held two cycles; outputs must be zero after the first edge.
        step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        idle(2);

        // Write then immediate read of the same word.
        step(1'b0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
        step(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
        idle(6);

        // Burst fill: 8 writes then 8 back-to-back reads.
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, 1'b1, 16'(16'h0120 + 2 * i), 16'(16'hA000 + i));
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, 1'b0, 16'(16'h0120 + 2 * i), 16'h0);
        idle(6);

        // Bubbles: reads in c0, c2, c3.
        step(1'b0, 1'b1, 1'b0, 16'h0120, 16'h0);
        step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b0, 1'b1, 1'b0, 16'h0122, 16'h0);
        step(1'b0, 1'b1, 1'b0, 16'h0124, 16'h0);
        idle(6);

        // Reset mid-flight, with a write in the reset cycle, then a fresh read.
        step(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
        step(1'b0, 1'b1, 1'b0, 16'h0120, 16'h0);
        step(1'b1, 1'b1, 1'b1, 16'h0010, 16'h5555);
        idle(4);
        step(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
        idle(6);

        // Aliasing and read-before-write ordering.
        step(1'b0, 1'b1, 1'b1, 16'h0000, 16'h1111);
        step(1'b0, 1'b1, 1'b1, 16'h0800, 16'h2222);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0);
        step(1'b0, 1'b1, 1'b1, 16'h0000, 16'h3333);
        step(1'b0, 1'b1, 1'b0, 16'h0001, 16'h0);
        idle(6);

        // Random traffic over a small aliased window with occasional resets.
        for (int i = 0; i < 400; i++) begin
            bit r, e, w;
            logic [15:0] a, d;
            r = ($urandom_range(0, 39) == 0);
            e = ($urandom_range(0, 9) < 7);
            w = ($urandom_range(0, 9) < 4);
            a = 16'(($urandom & 32'hF800) | ($urandom_range(0, 31) << 1) | ($urandom & 1));
            d = 16'($urandom);
            step(r, e, w, a, d);
        end
        idle(LAT + 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
